// File: rtl/reg_file_pkg.sv
// Shared types for the register bank: write-source encoding and its priority decode.
package reg_file_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ACC,
    SRC_LOAD,
    SRC_SE
  } wr_src_e;

  function automatic wr_src_e wr_src(input logic lacc, input logic ldm, input logic lse);
    if (lacc) return SRC_ACC;
    if (ldm)  return SRC_LOAD;
    if (lse)  return SRC_SE;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/reg_file_bank_if.sv
// Datapath-side bundle of the register bank: write sources, reserve, two read ports.
interface reg_file_bank_if
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned NREGS = 4
);
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             lacc;
  logic             ldm;
  logic             lse;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] se;
  logic [AW-1:0]    wr_addr;
  logic             rsv;
  logic [AW-1:0]    rsv_addr;
  logic             rd_en;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             valid_a;
  logic             valid_b;
  logic [NREGS-1:0] pending;

  modport master (
    output lacc, ldm, lse, acc, load, se, wr_addr, rsv, rsv_addr,
           rd_en, rd_addr_a, rd_addr_b,
    input  out_a, out_b, valid_a, valid_b, pending
  );

  modport slave (
    input  lacc, ldm, lse, acc, load, se, wr_addr, rsv, rsv_addr,
           rd_en, rd_addr_a, rd_addr_b,
    output out_a, out_b, valid_a, valid_b, pending
  );

endinterface

// File: rtl/reg_file_wr_sel.sv
// Fixed-priority write-source select: accumulator over memory load over sign-extend.
module reg_file_wr_sel
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             lacc,
  input  logic             ldm,
  input  logic             lse,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] load,
  input  logic [WIDTH-1:0] se,
  output logic             we,
  output logic [WIDTH-1:0] wdata
);

  always_comb begin
    we    = 1'b0;
    wdata = '0;
    case (wr_src(lacc, ldm, lse))
      SRC_ACC:  begin we = 1'b1; wdata = acc;  end
      SRC_LOAD: begin we = 1'b1; wdata = load; end
      SRC_SE:   begin we = 1'b1; wdata = se;   end
      default:  ;
    endcase
  end

endmodule

// File: rtl/reg_file_bank.sv
// NREGS x WIDTH register bank with pending scoreboard and two registered, bypassed read ports.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned NREGS = 4
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_bank_if.slave bus
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             wr_ok;
  logic             rsv_ok;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  reg_file_wr_sel #(.WIDTH(WIDTH)) u_wr_sel (
    .lacc  (bus.lacc),
    .ldm   (bus.ldm),
    .lse   (bus.lse),
    .acc   (bus.acc),
    .load  (bus.load),
    .se    (bus.se),
    .we    (we),
    .wdata (wdata)
  );

  assign wr_ok  = 32'(bus.wr_addr)  < NREGS;
  assign rsv_ok = 32'(bus.rsv_addr) < NREGS;

  // Reserve is applied after the write so a same-address reserve leaves the register pending.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (we && wr_ok) begin
      regs_d[bus.wr_addr]    = wdata;
      pending_d[bus.wr_addr] = 1'b0;
    end
    if (bus.rsv && rsv_ok) begin
      pending_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             rd_ok;
    logic [WIDTH-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    assign addr  = (p == 0) ? bus.rd_addr_a : bus.rd_addr_b;
    assign rd_ok = 32'(addr) < NREGS;

    // Validity looks at the post-edge scoreboard so same-cycle reserves and writes are seen.
    always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      if (bus.rd_en) begin
        if (rd_ok) begin
          out_d   = (we && bus.wr_addr == addr) ? wdata : regs_q[addr];
          valid_d = !pending_d[addr];
        end else begin
          out_d   = '0;
          valid_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= out_d;
        valid_q <= valid_d;
      end
    end
  end

  assign bus.out_a   = g_rd[0].out_q;
  assign bus.valid_a = g_rd[0].valid_q;
  assign bus.out_b   = g_rd[1].out_q;
  assign bus.valid_b = g_rd[1].valid_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed scoreboard bench for reg_file_bank: a 4-entry bank and a 3-entry bank share clk/rst.
module tb_reg_file_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_bank_if #(.WIDTH(16), .NREGS(4)) bus4 ();
  reg_file_bank_if #(.WIDTH(16), .NREGS(3)) bus3 ();

  reg_file_bank #(.WIDTH(16), .NREGS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  reg_file_bank #(.WIDTH(16), .NREGS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    string       tag;
    logic [15:0] oa;
    logic        va;
    logic [15:0] ob;
    logic        vb;
    logic [3:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_out(input string tag, input logic [15:0] oa, input logic va,
                            input logic [15:0] ob, input logic vb, input logic [3:0] pend);
    exp_t e;
    e.tag = tag; e.oa = oa; e.va = va; e.ob = ob; e.vb = vb; e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_now(input int d);
    exp_t e;
    logic [15:0] oa, ob;
    logic        va, vb;
    logic [3:0]  pend;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    if (d == 4) begin
      oa = bus4.out_a; va = bus4.valid_a; ob = bus4.out_b; vb = bus4.valid_b; pend = bus4.pending;
    end else begin
      oa = bus3.out_a; va = bus3.valid_a; ob = bus3.out_b; vb = bus3.valid_b; pend = {1'b0, bus3.pending};
    end
    cmp(e.tag, "out_a",   oa,            e.oa);
    cmp(e.tag, "valid_a", {15'd0, va},   {15'd0, e.va});
    cmp(e.tag, "out_b",   ob,            e.ob);
    cmp(e.tag, "valid_b", {15'd0, vb},   {15'd0, e.vb});
    cmp(e.tag, "pending", {12'd0, pend}, {12'd0, e.pend});
  endtask

  task automatic tick_check(input int d);
    @(posedge clk);
    #1;
    check_now(d);
  endtask

  task automatic set_wr(input int d, input logic lacc, input logic ldm, input logic lse,
                        input logic [1:0] wa, input logic [15:0] acc, input logic [15:0] load,
                        input logic [15:0] se);
    if (d == 4) begin
      bus4.lacc = lacc; bus4.ldm = ldm; bus4.lse = lse; bus4.wr_addr = wa;
      bus4.acc = acc; bus4.load = load; bus4.se = se;
    end else begin
      bus3.lacc = lacc; bus3.ldm = ldm; bus3.lse = lse; bus3.wr_addr = wa;
      bus3.acc = acc; bus3.load = load; bus3.se = se;
    end
  endtask

  task automatic set_rsv(input int d, input logic en, input logic [1:0] a);
    if (d == 4) begin bus4.rsv = en; bus4.rsv_addr = a; end
    else        begin bus3.rsv = en; bus3.rsv_addr = a; end
  endtask

  task automatic set_rd(input int d, input logic en, input logic [1:0] a, input logic [1:0] b);
    if (d == 4) begin bus4.rd_en = en; bus4.rd_addr_a = a; bus4.rd_addr_b = b; end
    else        begin bus3.rd_en = en; bus3.rd_addr_a = a; bus3.rd_addr_b = b; end
  endtask

  task automatic idle(input int d);
    set_wr(d, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0);
    set_rsv(d, 1'b0, 2'd0);
  endtask

  initial begin
    idle(4); idle(3);
    set_rd(4, 1'b0, 2'd0, 2'd0);
    set_rd(3, 1'b0, 2'd0, 2'd0);

    // Reset state, then release away from the clock edge
    #12;
    expect_out("reset4", 16'h0, 1'b0, 16'h0, 1'b0, 4'b0000); check_now(4);
    expect_out("reset3", 16'h0, 1'b0, 16'h0, 1'b0, 4'b0000); check_now(3);
    rst = 1'b1;

    // ---------- 4-entry bank ----------
    set_rd(4, 1'b1, 2'd0, 2'd3);
    expect_out("rd_after_reset", 16'h0, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(4);

    set_wr(4, 1'b1, 1'b1, 1'b1, 2'd2, 16'h1111, 16'h2222, 16'h3333); set_rd(4, 1'b1, 2'd2, 2'd3);
    expect_out("prio_acc", 16'h1111, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(4);

    set_wr(4, 1'b0, 1'b1, 1'b1, 2'd2, 16'h1111, 16'h2222, 16'h3333);
    expect_out("prio_load", 16'h2222, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(4);

    idle(4); set_rd(4, 1'b1, 2'd2, 2'd0);
    expect_out("reg2_stored", 16'h2222, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(4);

    set_wr(4, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 16'h0, 16'hBEEF); set_rd(4, 1'b1, 2'd1, 2'd2);
    expect_out("bypass_se", 16'hBEEF, 1'b1, 16'h2222, 1'b1, 4'b0000); tick_check(4);

    idle(4); set_rsv(4, 1'b1, 2'd3); set_rd(4, 1'b1, 2'd1, 2'd3);
    expect_out("rsv3", 16'hBEEF, 1'b1, 16'h0, 1'b0, 4'b1000); tick_check(4);

    idle(4); set_wr(4, 1'b1, 1'b0, 1'b0, 2'd3, 16'h0042, 16'h0, 16'h0); set_rd(4, 1'b1, 2'd3, 2'd3);
    expect_out("fill3", 16'h0042, 1'b1, 16'h0042, 1'b1, 4'b0000); tick_check(4);

    idle(4); set_rd(4, 1'b1, 2'd0, 2'd3);
    expect_out("read3", 16'h0, 1'b1, 16'h0042, 1'b1, 4'b0000); tick_check(4);

    set_rsv(4, 1'b1, 2'd3); set_wr(4, 1'b0, 1'b0, 1'b1, 2'd3, 16'h0, 16'h0, 16'h5A5A);
    set_rd(4, 1'b1, 2'd2, 2'd3);
    expect_out("rsv_and_wr", 16'h2222, 1'b1, 16'h5A5A, 1'b0, 4'b1000); tick_check(4);

    idle(4); set_rd(4, 1'b1, 2'd3, 2'd3);
    expect_out("rsv_wr_data", 16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 4'b1000); tick_check(4);

    set_wr(4, 1'b1, 1'b0, 1'b0, 2'd0, 16'hA0A0, 16'h0, 16'h0); set_rd(4, 1'b1, 2'd0, 2'd3);
    expect_out("load0", 16'hA0A0, 1'b1, 16'h5A5A, 1'b0, 4'b1000); tick_check(4);

    set_wr(4, 1'b0, 1'b1, 1'b0, 2'd3, 16'h0, 16'h7777, 16'h0); set_rd(4, 1'b1, 2'd3, 2'd1);
    expect_out("load3", 16'h7777, 1'b1, 16'hBEEF, 1'b1, 4'b0000); tick_check(4);

    idle(4); set_rsv(4, 1'b1, 2'd1); set_rd(4, 1'b1, 2'd1, 2'd2);
    expect_out("rsv1", 16'hBEEF, 1'b0, 16'h2222, 1'b1, 4'b0010); tick_check(4);

    // Mid-run reset takes effect without a clock edge
    idle(4);
    #2 rst = 1'b0;
    #1;
    expect_out("mid_reset", 16'h0, 1'b0, 16'h0, 1'b0, 4'b0000); check_now(4);
    #2 rst = 1'b1;

    set_rd(4, 1'b1, 2'd0, 2'd2);
    expect_out("post_reset_02", 16'h0, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(4);
    set_rd(4, 1'b1, 2'd1, 2'd3);
    expect_out("post_reset_13", 16'h0, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(4);
    set_rd(4, 1'b0, 2'd0, 2'd0);

    // ---------- 3-entry bank ----------
    set_wr(3, 1'b1, 1'b0, 1'b0, 2'd2, 16'h1234, 16'h0, 16'h0); set_rd(3, 1'b1, 2'd2, 2'd0);
    expect_out("n3_wr2", 16'h1234, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(3);

    set_wr(3, 1'b1, 1'b0, 1'b0, 2'd3, 16'hFFFF, 16'h0, 16'h0); set_rsv(3, 1'b1, 2'd3);
    expect_out("n3_wr_oor", 16'h1234, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(3);

    idle(3); set_rd(3, 1'b1, 2'd0, 2'd1);
    expect_out("n3_unchanged", 16'h0, 1'b1, 16'h0, 1'b1, 4'b0000); tick_check(3);

    set_rd(3, 1'b1, 2'd3, 2'd2);
    expect_out("n3_rd_oor", 16'h0, 1'b0, 16'h1234, 1'b1, 4'b0000); tick_check(3);

    set_rd(3, 1'b0, 2'd2, 2'd2); set_wr(3, 1'b1, 1'b0, 1'b0, 2'd2, 16'h9999, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("n3_hold%0d", i), 16'h0, 1'b0, 16'h1234, 1'b1, 4'b0000);
      tick_check(3);
      idle(3);
    end

    set_rd(3, 1'b1, 2'd2, 2'd3);
    expect_out("n3_after_hold", 16'h9999, 1'b1, 16'h0, 1'b0, 4'b0000); tick_check(3);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
